// File: rtl/seq_div.sv
// Sequential signed divider: a 2*WIDTH-bit dividend divided by a WIDTH-bit divisor.
// It performs radix-2 restoring division on the magnitudes and produces one quotient
// bit per cycle. The quotient truncates toward zero, and the remainder takes the sign
// of the dividend.
module seq_div #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [2*WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]     divisor_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WIDTH-1:0]     quotient_o,
    output logic [WIDTH-1:0]     remainder_o,
    output logic                 div_by_zero_o,
    output logic                 overflow_o
);

    localparam int unsigned       CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  QPosMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]  QNegMax = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StLoad, StIter, StFix} state_e;

    state_e state_q, state_d;

    // Operands as sampled at the accept edge
    logic [2*WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               qneg_q;
    logic               rneg_q;

    // Iteration datapath
    logic [WIDTH-1:0]   lo_q;     // low dividend bits still to be shifted in, MSB first
    logic [WIDTH-1:0]   rem_q;    // partial remainder
    logic [WIDTH-1:0]   quo_q;    // unsigned quotient being built
    logic [WIDTH:0]     udvs_q;   // |divisor|, one extra bit so that -2^(W-1) fits
    logic [CntW-1:0]    cnt_q;
    logic               div0_q;
    logic               ovf_q;

    // Registered results
    logic               done_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               div_by_zero_q;
    logic               overflow_q;

    logic [2*WIDTH-1:0] abs_dvd;
    logic [WIDTH:0]     dvs_ext;
    logic [WIDTH:0]     abs_dvs;
    logic               load_div0;
    logic               load_ovf;
    logic [WIDTH:0]     shifted;
    logic               geq;
    logic [WIDTH-1:0]   diff;
    logic               fix_ovf;
    logic               fix_bad;
    logic [WIDTH-1:0]   q_signed;
    logic [WIDTH-1:0]   r_signed;

    // Datapath combinational helpers for each phase
    always_comb begin
        abs_dvd   = dvd_q[2*WIDTH-1] ? -dvd_q : dvd_q;
        dvs_ext   = {dvs_q[WIDTH-1], dvs_q};
        abs_dvs   = dvs_ext[WIDTH] ? -dvs_ext : dvs_ext;
        load_div0 = (dvs_q == '0);
        load_ovf  = ({1'b0, abs_dvd[2*WIDTH-1:WIDTH]} >= abs_dvs);
        shifted   = {rem_q, lo_q[WIDTH-1]};
        geq       = (shifted >= udvs_q);
        // When geq holds, the true difference is below |divisor| <= 2^(W-1), so W bits suffice.
        diff      = shifted[WIDTH-1:0] - udvs_q[WIDTH-1:0];
        fix_ovf   = qneg_q ? (quo_q > QNegMax) : (quo_q > QPosMax);
        fix_bad   = div0_q | ovf_q | fix_ovf;
        q_signed  = qneg_q ? -quo_q : quo_q;
        r_signed  = rneg_q ? -rem_q : rem_q;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StLoad;
            StLoad:  state_d = StIter;
            StIter:  if (cnt_q == CntLast) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, iteration, sign fix-up and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dvd_q         <= '0;
            dvs_q         <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            lo_q          <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            udvs_q        <= '0;
            cnt_q         <= '0;
            div0_q        <= 1'b0;
            ovf_q         <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        dvd_q         <= dividend_i;
                        dvs_q         <= divisor_i;
                        qneg_q        <= dividend_i[2*WIDTH-1] ^ divisor_i[WIDTH-1];
                        rneg_q        <= dividend_i[2*WIDTH-1];
                        quotient_q    <= '0;
                        remainder_q   <= '0;
                        div_by_zero_q <= 1'b0;
                        overflow_q    <= 1'b0;
                    end
                end
                StLoad: begin
                    lo_q   <= abs_dvd[WIDTH-1:0];
                    rem_q  <= abs_dvd[2*WIDTH-1:WIDTH];
                    udvs_q <= abs_dvs;
                    quo_q  <= '0;
                    cnt_q  <= '0;
                    div0_q <= load_div0;
                    ovf_q  <= !load_div0 && load_ovf;
                end
                StIter: begin
                    // Always runs the full WIDTH steps, even when flagged, to keep latency fixed
                    lo_q  <= lo_q << 1;
                    rem_q <= geq ? diff : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], geq};
                    cnt_q <= cnt_q + 1'b1;
                end
                StFix: begin
                    quotient_q    <= fix_bad ? '0 : q_signed;
                    remainder_q   <= fix_bad ? '0 : r_signed;
                    div_by_zero_q <= div0_q;
                    overflow_q    <= !div0_q && (ovf_q || fix_ovf);
                    done_q        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = div_by_zero_q;
    assign overflow_o    = overflow_q;

endmodule
